// File: rtl/wave_pkg.sv
// Shared definitions for the waveform generator / checker pair.
// Both ends take their default pattern and period from here so they agree
// on what is sent and what is expected.
package wave_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [7:0] DEF_PATTERN = 8'h0A;
   localparam int         DEF_PAT_LEN = 5;

   // Pattern bit i is sent i-th, so after a full period in a left-shifting
   // window it sits at position len-1-i. Returns the pattern in that order.
   function automatic logic [7:0] window_order(input logic [7:0] pat, input int len);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < len) r[len-1-i] = pat[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/wave_sat_counter.sv
// Saturating up-counter with a clear that overrides a same-cycle increment.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high
//   inc    in   count up by one (holds at all-ones)
//   clr    in   force count to zero, wins over inc
//   count  out  current count
module wave_sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/wave_pattern_checker.sv
// Receive-side checker for the repeating serial test pattern. Aligns to the
// pattern, declares lock after a run of good samples, counts bit errors while
// locked, and flags a clock-wave that fails to toggle.
// Ports:
//   clock           in   rising-edge clock
//   reset           in   synchronous, active-high
//   io_sampleValid  in   io_sampleBit is valid this cycle
//   io_sampleBit    in   received pattern bit
//   io_clockWave    in   received clock-wave, checked every cycle
//   io_clearErrors  in   pulse; zeroes io_errorCount
//   io_locked       out  high while locked
//   io_bitError     out  one-cycle pulse per bad sample while locked
//   io_errorCount   out  saturating count of locked bit errors
//   io_clockError   out  one-cycle pulse when the clock-wave did not toggle
//
// state  | meaning
// SEARCH | sliding window compared against the pattern every valid sample
// VERIFY | candidate alignment; counting consecutive good samples
// LOCKED | aligned; bad samples are errors, a run of them drops lock
module wave_pattern_checker
   import wave_pkg::*;
#(
   parameter logic [7:0] PATTERN    = DEF_PATTERN,
   parameter int         PAT_LEN    = DEF_PAT_LEN,
   parameter int         LOCK_COUNT = 8,
   parameter int         LOSS_LIMIT = 3,
   parameter int         CNT_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_sampleValid,
   input  logic                 io_sampleBit,
   input  logic                 io_clockWave,
   input  logic                 io_clearErrors,
   output logic                 io_locked,
   output logic                 io_bitError,
   output logic [CNT_WIDTH-1:0] io_errorCount,
   output logic                 io_clockError
);

   localparam int PH_W   = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int BAD_W  = $clog2(LOSS_LIMIT + 1);

   localparam logic [PAT_LEN-1:0] PAT_REF   = PAT_LEN'(window_order(PATTERN, PAT_LEN));
   localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(PAT_LEN);
   localparam logic [PH_W-1:0]    PH_LAST   = PH_W'(PAT_LEN - 1);
   localparam logic [GOOD_W-1:0]  GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
   localparam logic [BAD_W-1:0]   BAD_LAST  = BAD_W'(LOSS_LIMIT - 1);

   state_t              state;
   logic [PAT_LEN-1:0]  window;
   logic [FILL_W-1:0]   fill;
   logic [PH_W-1:0]     phase;
   logic [GOOD_W-1:0]   good;
   logic [BAD_W-1:0]    bad;
   logic                wave_prev;
   logic                primed;

   logic [PAT_LEN-1:0]  window_nxt;
   logic [FILL_W-1:0]   fill_nxt;
   logic [PH_W-1:0]     phase_inc;
   logic [2:0]          phase_idx;
   logic                good_sample;
   logic                match;
   logic                err_inc;

   // Match is judged on the window including this cycle's bit, so a clean
   // stream from reset aligns on its PAT_LEN-th sample.
   assign window_nxt  = {window[PAT_LEN-2:0], io_sampleBit};
   assign fill_nxt    = (fill == FILL_MAX) ? fill : fill + 1'b1;
   assign match       = (fill_nxt == FILL_MAX) && (window_nxt == PAT_REF);
   assign phase_inc   = (phase == PH_LAST) ? '0 : phase + 1'b1;
   assign phase_idx   = 3'(phase);
   assign good_sample = (io_sampleBit == PATTERN[phase_idx]);
   assign err_inc     = io_sampleValid && (state == LOCKED) && !good_sample;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= SEARCH;
         window        <= '0;
         fill          <= '0;
         phase         <= '0;
         good          <= '0;
         bad           <= '0;
         wave_prev     <= 1'b0;
         primed        <= 1'b0;
         io_locked     <= 1'b0;
         io_bitError   <= 1'b0;
         io_clockError <= 1'b0;
      end else begin
         io_bitError   <= 1'b0;
         io_clockError <= primed && (io_clockWave == wave_prev);
         wave_prev     <= io_clockWave;
         primed        <= 1'b1;
         if (io_sampleValid) begin
            window <= window_nxt;
            fill   <= fill_nxt;
            case (state)
               SEARCH: begin
                  if (match) begin
                     phase <= '0;
                     good  <= '0;
                     state <= VERIFY;
                  end
               end
               VERIFY: begin
                  if (good_sample) begin
                     good  <= good + 1'b1;
                     phase <= phase_inc;
                     if (good == GOOD_LAST) begin
                        state     <= LOCKED;
                        io_locked <= 1'b1;
                        bad       <= '0;
                     end
                  end else begin
                     state <= SEARCH;
                  end
               end
               LOCKED: begin
                  phase <= phase_inc;
                  if (good_sample) begin
                     bad <= '0;
                  end else begin
                     io_bitError <= 1'b1;
                     bad         <= bad + 1'b1;
                     if (bad == BAD_LAST) begin
                        state     <= SEARCH;
                        io_locked <= 1'b0;
                     end
                  end
               end
               default: begin
                  state     <= SEARCH;
                  io_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   wave_sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (err_inc),
      .clr   (io_clearErrors),
      .count (io_errorCount)
   );

endmodule

// File: tb/tb_wave_pattern_checker.sv
module tb_wave_pattern_checker;

   localparam int PL    = 5;
   localparam int LOCKN = 8;

   logic clock = 1'b0;
   logic rst = 1'b1;
   logic valid = 1'b0;
   logic bit_in = 1'b0;
   logic wave = 1'b0;
   logic clr = 1'b0;

   logic        locked_a, bit_error_a, clock_error_a;
   logic [15:0] count_a;
   logic        locked_b, bit_error_b, clock_error_b;
   logic [3:0]  count_b;

   logic [7:0] pat = 8'h0A;
   int gph = 0;

   int errors = 0;
   int checks = 0;

   // reference model: instance 0 = defaults, instance 1 = 4-bit count, loss 16
   int loss_lim[2] = '{3, 16};
   int cmax[2]     = '{65535, 15};
   bit hist[$];
   int md[2];            // 0 searching, 1 verifying, 2 locked
   int ph[2], gd[2], bd[2];
   int e_cnt[2];
   bit e_lock[2], e_berr[2];
   bit e_cerr, primed_m, prev_w;

   always #5 clock = ~clock;

   wave_pattern_checker dut_a (
      .clock(clock), .reset(rst), .io_sampleValid(valid), .io_sampleBit(bit_in),
      .io_clockWave(wave), .io_clearErrors(clr), .io_locked(locked_a),
      .io_bitError(bit_error_a), .io_errorCount(count_a), .io_clockError(clock_error_a)
   );

   wave_pattern_checker #(.CNT_WIDTH(4), .LOSS_LIMIT(16)) dut_b (
      .clock(clock), .reset(rst), .io_sampleValid(valid), .io_sampleBit(bit_in),
      .io_clockWave(wave), .io_clearErrors(clr), .io_locked(locked_b),
      .io_bitError(bit_error_b), .io_errorCount(count_b), .io_clockError(clock_error_b)
   );

   task automatic model_step(input logic v, input logic b, input logic w, input logic c, input logic r);
      if (r) begin
         hist.delete();
         primed_m = 0;
         e_cerr   = 0;
         for (int m = 0; m < 2; m++) begin
            md[m] = 0; ph[m] = 0; gd[m] = 0; bd[m] = 0;
            e_cnt[m] = 0; e_lock[m] = 0; e_berr[m] = 0;
         end
      end else begin
         e_cerr   = primed_m && (w == prev_w);
         prev_w   = w;
         primed_m = 1;
         if (v) begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
         end
         for (int m = 0; m < 2; m++) begin
            bit inc;
            bit ok;
            inc = 0;
            e_berr[m] = 0;
            if (v) begin
               if (md[m] == 0) begin
                  if (hist.size() >= PL) begin
                     ok = 1;
                     for (int i = 0; i < PL; i++)
                        if (hist[hist.size() - PL + i] != pat[i]) ok = 0;
                     if (ok) begin md[m] = 1; ph[m] = 0; gd[m] = 0; end
                  end
               end else if (md[m] == 1) begin
                  if (b == pat[ph[m]]) begin
                     gd[m]++;
                     ph[m] = (ph[m] + 1) % PL;
                     if (gd[m] == LOCKN) begin md[m] = 2; bd[m] = 0; end
                  end else begin
                     md[m] = 0;
                  end
               end else begin
                  ok = (b == pat[ph[m]]);
                  ph[m] = (ph[m] + 1) % PL;
                  if (ok) bd[m] = 0;
                  else begin
                     e_berr[m] = 1;
                     inc = 1;
                     bd[m]++;
                     if (bd[m] == loss_lim[m]) md[m] = 0;
                  end
               end
            end
            if (c) e_cnt[m] = 0;
            else if (inc && e_cnt[m] < cmax[m]) e_cnt[m]++;
            e_lock[m] = (md[m] == 2);
         end
      end
   endtask

   task automatic step(input logic v, input logic b, input logic c, input logic r, input logic hold);
      if (!hold) wave = ~wave;
      valid  = v;
      bit_in = b;
      clr    = c;
      rst    = r;
      model_step(v, b, wave, c, r);
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic flip, input logic hold);
      step(1'b1, pat[gph] ^ flip, 1'b0, 1'b0, hold);
      gph = (gph + 1) % PL;
   endtask

   task automatic test_reset;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      gph = 0;
      checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL reset_locked_a: got %b want 0", locked_a); end
      checks++; if (bit_error_a !== 1'b0) begin errors++; $display("FAIL reset_biterr_a: got %b want 0", bit_error_a); end
      checks++; if (count_a !== 16'd0) begin errors++; $display("FAIL reset_count_a: got %0d want 0", count_a); end
      checks++; if (clock_error_a !== 1'b0) begin errors++; $display("FAIL reset_clkerr_a: got %b want 0", clock_error_a); end
      checks++; if (locked_b !== 1'b0) begin errors++; $display("FAIL reset_locked_b: got %b want 0", locked_b); end
      checks++; if (count_b !== 4'd0) begin errors++; $display("FAIL reset_count_b: got %0d want 0", count_b); end
   endtask

   task automatic test_lock_acquire;
      for (int s = 1; s <= 13; s++) begin
         send(1'b0, 1'b0);
         checks++;
         if (locked_a !== (s == 13)) begin
            errors++; $display("FAIL acquire_locked_a sample %0d: got %b want %b", s, locked_a, (s == 13));
         end
         checks++;
         if (locked_b !== e_lock[1]) begin
            errors++; $display("FAIL acquire_locked_b sample %0d: got %b want %b", s, locked_b, e_lock[1]);
         end
         checks++;
         if (clock_error_a !== 1'b0 || count_a !== 16'd0 || bit_error_a !== 1'b0) begin
            errors++; $display("FAIL acquire_quiet_a sample %0d: clkerr %b count %0d biterr %b want 0 0 0",
                               s, clock_error_a, count_a, bit_error_a);
         end
      end
   endtask

   task automatic test_single_error;
      send(1'b1, 1'b0);
      checks++; if (bit_error_a !== 1'b1) begin errors++; $display("FAIL single_biterr_a: got %b want 1", bit_error_a); end
      checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL single_count_a: got %0d want 1", count_a); end
      checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL single_locked_a: got %b want 1", locked_a); end
      checks++; if (count_b !== 4'd1) begin errors++; $display("FAIL single_count_b: got %0d want 1", count_b); end
      send(1'b0, 1'b0);
      checks++; if (bit_error_a !== 1'b0) begin errors++; $display("FAIL single_biterr_clear_a: got %b want 0", bit_error_a); end
   endtask

   task automatic test_burst_error;
      while (gph != 2) send(1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         send(1'b1, 1'b0);
         checks++;
         if (locked_a !== (k < 3)) begin
            errors++; $display("FAIL burst_locked_a flip %0d: got %b want %b", k, locked_a, (k < 3));
         end
         checks++;
         if (bit_error_a !== 1'b1) begin
            errors++; $display("FAIL burst_biterr_a flip %0d: got %b want 1", k, bit_error_a);
         end
      end
      checks++; if (count_a !== 16'd4) begin errors++; $display("FAIL burst_count_a: got %0d want 4", count_a); end
      checks++; if (locked_b !== 1'b1) begin errors++; $display("FAIL burst_locked_b: got %b want 1", locked_b); end
      for (int k = 1; k <= 13; k++) begin
         send(1'b0, 1'b0);
         checks++;
         if (locked_a !== e_lock[0]) begin
            errors++; $display("FAIL relock_locked_a good %0d: got %b want %b", k, locked_a, e_lock[0]);
         end
      end
      checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL relock_final_a: got %b want 1", locked_a); end
      checks++; if (count_a !== 16'd4) begin errors++; $display("FAIL relock_count_a: got %0d want 4", count_a); end
   endtask

   task automatic test_valid_gap;
      int gap;
      gap = 10;
      for (int k = 0; k < gap; k++) begin
         step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
         checks++;
         if (locked_a !== 1'b1 || bit_error_a !== 1'b0 || locked_b !== 1'b1) begin
            errors++; $display("FAIL gap_hold idle %0d: locked_a %b biterr_a %b locked_b %b want 1 0 1",
                               k, locked_a, bit_error_a, locked_b);
         end
      end
      for (int k = 0; k < 7; k++) begin
         send(1'b0, 1'b0);
         checks++;
         if (locked_a !== 1'b1 || bit_error_a !== 1'b0) begin
            errors++; $display("FAIL gap_resume %0d: locked_a %b biterr_a %b want 1 0", k, locked_a, bit_error_a);
         end
      end
      checks++; if (count_a !== 16'd4) begin errors++; $display("FAIL gap_count_a: got %0d want 4", count_a); end
   endtask

   task automatic test_saturation;
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (count_a !== 16'd0 || count_b !== 4'd0) begin
         errors++; $display("FAIL clear_counts: got a=%0d b=%0d want 0 0", count_a, count_b);
      end
      for (int k = 0; k < 20; k++) begin
         send(1'b1, 1'b0);
         send(1'b0, 1'b0);
      end
      checks++; if (count_b !== 4'd15) begin errors++; $display("FAIL sat_count_b: got %0d want 15", count_b); end
      checks++; if (count_a !== 16'd20) begin errors++; $display("FAIL sat_count_a: got %0d want 20", count_a); end
      checks++; if (locked_a !== 1'b1 || locked_b !== 1'b1) begin
         errors++; $display("FAIL sat_locked: got a=%b b=%b want 1 1", locked_a, locked_b);
      end
      step(1'b1, ~pat[gph], 1'b1, 1'b0, 1'b0);
      gph = (gph + 1) % PL;
      checks++; if (count_a !== 16'd0 || count_b !== 4'd0) begin
         errors++; $display("FAIL clear_vs_inc: got a=%0d b=%0d want 0 0", count_a, count_b);
      end
      checks++; if (bit_error_a !== 1'b1) begin errors++; $display("FAIL clear_vs_inc_biterr_a: got %b want 1", bit_error_a); end
   endtask

   task automatic test_clock_and_reset;
      if (wave == 1'b1) send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      checks++; if (clock_error_a !== 1'b0) begin errors++; $display("FAIL clk_before_hold: got %b want 0", clock_error_a); end
      send(1'b0, 1'b1);
      checks++; if (clock_error_a !== 1'b1) begin errors++; $display("FAIL clk_hold_pulse_a: got %b want 1", clock_error_a); end
      checks++; if (clock_error_b !== 1'b1) begin errors++; $display("FAIL clk_hold_pulse_b: got %b want 1", clock_error_b); end
      send(1'b0, 1'b0);
      checks++; if (clock_error_a !== 1'b0) begin errors++; $display("FAIL clk_after_hold: got %b want 0", clock_error_a); end
      send(1'b0, 1'b1);
      checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL pre_reset_locked_a: got %b want 1", locked_a); end
      step(1'b1, ~pat[gph], 1'b1, 1'b1, 1'b1);
      checks++; if (locked_a !== 1'b0 || bit_error_a !== 1'b0 || count_a !== 16'd0 || clock_error_a !== 1'b0) begin
         errors++; $display("FAIL midreset_a: locked %b biterr %b count %0d clkerr %b want all 0",
                            locked_a, bit_error_a, count_a, clock_error_a);
      end
      checks++; if (locked_b !== 1'b0 || bit_error_b !== 1'b0 || count_b !== 4'd0 || clock_error_b !== 1'b0) begin
         errors++; $display("FAIL midreset_b: locked %b biterr %b count %0d clkerr %b want all 0",
                            locked_b, bit_error_b, count_b, clock_error_b);
      end
   endtask

   task automatic test_random;
      logic v, f, c, h;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      gph = 0;
      for (int n = 0; n < 600; n++) begin
         v = ($urandom_range(0, 9) != 0);
         f = ($urandom_range(0, 24) == 0);
         c = ($urandom_range(0, 59) == 0);
         h = ($urandom_range(0, 39) == 0);
         if (v) begin
            step(1'b1, pat[gph] ^ f, c, 1'b0, h);
            gph = (gph + 1) % PL;
         end else begin
            step(1'b0, 1'($urandom), c, 1'b0, h);
         end
         checks++; if (locked_a !== e_lock[0]) begin errors++; $display("FAIL rand_locked_a cyc %0d: got %b want %b", n, locked_a, e_lock[0]); end
         checks++; if (bit_error_a !== e_berr[0]) begin errors++; $display("FAIL rand_biterr_a cyc %0d: got %b want %b", n, bit_error_a, e_berr[0]); end
         checks++; if (count_a !== 16'(e_cnt[0])) begin errors++; $display("FAIL rand_count_a cyc %0d: got %0d want %0d", n, count_a, e_cnt[0]); end
         checks++; if (clock_error_a !== e_cerr) begin errors++; $display("FAIL rand_clkerr_a cyc %0d: got %b want %b", n, clock_error_a, e_cerr); end
         checks++; if (locked_b !== e_lock[1]) begin errors++; $display("FAIL rand_locked_b cyc %0d: got %b want %b", n, locked_b, e_lock[1]); end
         checks++; if (bit_error_b !== e_berr[1]) begin errors++; $display("FAIL rand_biterr_b cyc %0d: got %b want %b", n, bit_error_b, e_berr[1]); end
         checks++; if (count_b !== 4'(e_cnt[1])) begin errors++; $display("FAIL rand_count_b cyc %0d: got %0d want %0d", n, count_b, e_cnt[1]); end
         checks++; if (clock_error_b !== e_cerr) begin errors++; $display("FAIL rand_clkerr_b cyc %0d: got %b want %b", n, clock_error_b, e_cerr); end
      end
   endtask

   initial begin
      test_reset();
      test_lock_acquire();
      test_single_error();
      test_burst_error();
      test_valid_gap();
      test_saturation();
      test_clock_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
